// File: rtl/bcd_updown_counter.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_updown_counter
//  Purpose  : Registered multi-digit BCD up/down counter. It supports
//             synchronous clear, validated parallel load, and wrap or
//             saturate behaviour at the decade limits. The over/underflow
//             and load-error flags are one-cycle registered pulses.
//  Ports    : clk        - rising-edge clock
//             reset_n    - asynchronous active-low reset
//             clr        - synchronous clear (highest priority)
//             load       - synchronous load of load_data (if all nibbles BCD)
//             load_data  - BCD load value, digit 0 in [3:0]
//             incr/decr  - step up/down; both or neither = hold
//             data       - registered BCD count, digit 0 in [3:0]
//             ovf/udf    - pulse on up-step at all-9s / down-step at all-0s
//             load_err   - pulse when a load is rejected (non-BCD nibble)
//  Revision : 1.0  initial release
// ============================================================================
module bcd_updown_counter #(
   parameter int DIGITS   = 4,
   parameter bit SATURATE = 1'b0
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                clr,
   input  logic                load,
   input  logic [4*DIGITS-1:0] load_data,
   input  logic                incr,
   input  logic                decr,
   output logic [4*DIGITS-1:0] data,
   output logic                ovf,
   output logic                udf,
   output logic                load_err
);

   localparam int c_W = 4 * DIGITS;

   logic [c_W-1:0]    data_q, data_d;
   logic              ovf_q, ovf_d;
   logic              udf_q, udf_d;
   logic              load_err_q, load_err_d;

   // Carry/borrow ripple chains. Index 0 is the unconditional +1/-1 applied
   // to digit 0. Index DIGITS set means every digit was at its limit.
   logic [DIGITS:0]   w_carry;
   logic [DIGITS:0]   w_borrow;
   logic [c_W-1:0]    w_up_val;
   logic [c_W-1:0]    w_dn_val;
   logic [DIGITS-1:0] w_nib_ok;
   logic              w_all9;
   logic              w_all0;

   assign w_carry[0]  = 1'b1;
   assign w_borrow[0] = 1'b1;

   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      logic [3:0] w_dig;
      assign w_dig = data_q[4*i +: 4];

      assign w_carry[i+1]  = w_carry[i]  & (w_dig == 4'd9);
      assign w_borrow[i+1] = w_borrow[i] & (w_dig == 4'd0);

      assign w_up_val[4*i +: 4] = !w_carry[i]      ? w_dig :
                                  (w_dig == 4'd9)  ? 4'd0  : w_dig + 4'd1;
      assign w_dn_val[4*i +: 4] = !w_borrow[i]     ? w_dig :
                                  (w_dig == 4'd0)  ? 4'd9  : w_dig - 4'd1;

      assign w_nib_ok[i] = (load_data[4*i +: 4] <= 4'd9);
   end

   assign w_all9 = w_carry[DIGITS];
   assign w_all0 = w_borrow[DIGITS];

   always_comb begin
      data_d     = data_q;
      ovf_d      = 1'b0;
      udf_d      = 1'b0;
      load_err_d = 1'b0;
      if (clr) begin
         data_d = '0;
      end else if (load) begin
         // A load with any non-BCD nibble is rejected whole so that data
         // can never hold an illegal digit.
         if (&w_nib_ok) begin
            data_d = load_data;
         end else begin
            load_err_d = 1'b1;
         end
      end else if (incr && !decr) begin
         if (w_all9) begin
            ovf_d  = 1'b1;
            data_d = SATURATE ? data_q : '0;
         end else begin
            data_d = w_up_val;
         end
      end else if (decr && !incr) begin
         if (w_all0) begin
            udf_d  = 1'b1;
            data_d = SATURATE ? data_q : {DIGITS{4'h9}};
         end else begin
            data_d = w_dn_val;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_q     <= '0;
         ovf_q      <= 1'b0;
         udf_q      <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         data_q     <= data_d;
         ovf_q      <= ovf_d;
         udf_q      <= udf_d;
         load_err_q <= load_err_d;
      end
   end

   assign data     = data_q;
   assign ovf      = ovf_q;
   assign udf      = udf_q;
   assign load_err = load_err_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_updown_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bcd_updown_counter
//  Purpose  : Directed self-checking bench for bcd_updown_counter. It drives
//             four instances: 4-digit wrap, 4-digit saturate, 1-digit wrap,
//             and 8-digit wrap.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bcd_updown_counter;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   // Instance A: DIGITS=4, wrap
   logic        a_clr = 0, a_load = 0, a_incr = 0, a_decr = 0;
   logic [15:0] a_ld = '0, a_data;
   logic        a_ovf, a_udf, a_lerr;
   // Instance S: DIGITS=4, saturate
   logic        s_clr = 0, s_load = 0, s_incr = 0, s_decr = 0;
   logic [15:0] s_ld = '0, s_data;
   logic        s_ovf, s_udf, s_lerr;
   // Instance C: DIGITS=1, wrap
   logic        c_clr = 0, c_load = 0, c_incr = 0, c_decr = 0;
   logic [3:0]  c_ld = '0, c_data;
   logic        c_ovf, c_udf, c_lerr;
   // Instance E: DIGITS=8, wrap
   logic        e_clr = 0, e_load = 0, e_incr = 0, e_decr = 0;
   logic [31:0] e_ld = '0, e_data;
   logic        e_ovf, e_udf, e_lerr;

   bcd_updown_counter #(.DIGITS(4), .SATURATE(1'b0)) u_a (
      .clk(clk), .reset_n(reset_n), .clr(a_clr), .load(a_load), .load_data(a_ld),
      .incr(a_incr), .decr(a_decr), .data(a_data), .ovf(a_ovf), .udf(a_udf),
      .load_err(a_lerr));
   bcd_updown_counter #(.DIGITS(4), .SATURATE(1'b1)) u_s (
      .clk(clk), .reset_n(reset_n), .clr(s_clr), .load(s_load), .load_data(s_ld),
      .incr(s_incr), .decr(s_decr), .data(s_data), .ovf(s_ovf), .udf(s_udf),
      .load_err(s_lerr));
   bcd_updown_counter #(.DIGITS(1), .SATURATE(1'b0)) u_c (
      .clk(clk), .reset_n(reset_n), .clr(c_clr), .load(c_load), .load_data(c_ld),
      .incr(c_incr), .decr(c_decr), .data(c_data), .ovf(c_ovf), .udf(c_udf),
      .load_err(c_lerr));
   bcd_updown_counter #(.DIGITS(8), .SATURATE(1'b0)) u_e (
      .clk(clk), .reset_n(reset_n), .clr(e_clr), .load(e_load), .load_data(e_ld),
      .incr(e_incr), .decr(e_decr), .data(e_data), .ovf(e_ovf), .udf(e_udf),
      .load_err(e_lerr));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one edge; outputs are sampled 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic a_op(input logic cl, input logic ld, input logic [15:0] v,
                       input logic up, input logic dn);
      a_clr = cl; a_load = ld; a_ld = v; a_incr = up; a_decr = dn;
      tick();
      a_clr = 0; a_load = 0; a_incr = 0; a_decr = 0;
   endtask

   task automatic s_op(input logic ld, input logic [15:0] v, input logic up, input logic dn);
      s_load = ld; s_ld = v; s_incr = up; s_decr = dn;
      tick();
      s_load = 0; s_incr = 0; s_decr = 0;
   endtask

   task automatic a_chk(input string tag, input logic [15:0] d, input logic o,
                        input logic u, input logic le);
      chk({tag, "_data"}, a_data, d);
      chk({tag, "_flags"}, {a_ovf, a_udf, a_lerr}, {o, u, le});
   endtask

   function automatic logic [31:0] to_bcd(input int unsigned v);
      logic [31:0] r;
      int unsigned x;
      x = v;
      for (int k = 0; k < 8; k++) begin
         r[4*k +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic logic all_bcd(input logic [31:0] v);
      logic ok;
      ok = 1'b1;
      for (int k = 0; k < 8; k++) if (v[4*k +: 4] > 4'd9) ok = 1'b0;
      return ok;
   endfunction

   initial begin
      int unsigned m;
      int unsigned prev;
      logic        up;

      // ---------------- reset ----------------
      #2;
      a_chk("reset", 16'h0000, 0, 0, 0);
      @(negedge clk);
      reset_n = 1'b1;

      // Reset mid-count without a clock edge
      a_op(0, 1, 16'h0123, 0, 0);
      a_chk("load_0123", 16'h0123, 0, 0, 0);
      reset_n = 1'b0;
      #2;
      a_chk("async_reset", 16'h0000, 0, 0, 0);
      #1 reset_n = 1'b1;

      // ---------------- A: up ripple / wrap ----------------
      a_op(0, 1, 16'h0999, 0, 0);
      a_op(0, 0, 16'h0000, 1, 0);
      a_chk("up_ripple", 16'h1000, 0, 0, 0);
      a_op(0, 1, 16'h9999, 0, 0);
      a_op(0, 0, 16'h0000, 1, 0);
      a_chk("up_wrap", 16'h0000, 1, 0, 0);
      a_op(0, 0, 16'h0000, 0, 0);
      a_chk("ovf_drop", 16'h0000, 0, 0, 0);

      // ---------------- A: down borrow / wrap ----------------
      a_op(0, 1, 16'h1000, 0, 0);
      a_op(0, 0, 16'h0000, 0, 1);
      a_chk("dn_borrow", 16'h0999, 0, 0, 0);
      a_op(0, 1, 16'h0000, 0, 0);
      a_op(0, 0, 16'h0000, 0, 1);
      a_chk("dn_wrap", 16'h9999, 0, 1, 0);
      a_op(0, 0, 16'h0000, 0, 0);
      a_chk("udf_drop", 16'h9999, 0, 0, 0);

      // ---------------- A: load validation / priority ----------------
      a_op(0, 1, 16'h12A4, 0, 0);
      a_chk("load_bad", 16'h9999, 0, 0, 1);
      a_op(0, 1, 16'hF000, 1, 0);
      a_chk("load_bad2", 16'h9999, 0, 0, 1);
      a_op(0, 0, 16'h0000, 0, 0);
      a_chk("lerr_drop", 16'h9999, 0, 0, 0);
      a_op(1, 1, 16'h0555, 1, 0);
      a_chk("clr_prio", 16'h0000, 0, 0, 0);
      a_op(0, 1, 16'h0042, 1, 0);
      a_chk("load_prio", 16'h0042, 0, 0, 0);
      a_op(0, 0, 16'h0000, 1, 1);
      a_chk("both_hold", 16'h0042, 0, 0, 0);
      a_op(0, 1, 16'h0000, 0, 0);
      a_op(0, 0, 16'h0000, 1, 1);
      a_chk("both_hold0", 16'h0000, 0, 0, 0);

      // Continuous up-count across a digit boundary
      a_op(0, 1, 16'h0197, 0, 0);
      a_incr = 1;
      tick(); a_chk("run1", 16'h0198, 0, 0, 0);
      tick(); a_chk("run2", 16'h0199, 0, 0, 0);
      tick(); a_chk("run3", 16'h0200, 0, 0, 0);
      tick(); a_chk("run4", 16'h0201, 0, 0, 0);
      a_incr = 0;

      // ---------------- S: saturate ----------------
      s_op(1, 16'h9999, 0, 0);
      chk("sat_load", s_data, 16'h9999);
      s_incr = 1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("sat_up_data", s_data, 16'h9999);
         chk("sat_up_ovf", s_ovf, 1'b1);
      end
      s_incr = 0;
      s_op(1, 16'h0000, 0, 0);
      chk("sat_ovf_drop", s_ovf, 1'b0);
      s_op(0, 16'h0000, 0, 1);
      chk("sat_dn_data", s_data, 16'h0000);
      chk("sat_dn_udf", s_udf, 1'b1);
      s_op(0, 16'h0000, 1, 0);
      chk("sat_recover", {s_data, s_ovf, s_udf}, {16'h0001, 1'b0, 1'b0});

      // ---------------- C: DIGITS=1 free run ----------------
      c_clr = 1; tick(); c_clr = 0;
      chk("d1_clr", c_data, 4'd0);
      m = 0;
      c_incr = 1;
      for (int k = 0; k < 12; k++) begin
         prev = m;
         m = (m + 1) % 10;
         tick();
         chk("d1_up_data", c_data, m);
         chk("d1_up_ovf", c_ovf, (prev == 9));
      end
      c_incr = 0;
      c_decr = 1;
      for (int k = 0; k < 4; k++) begin
         prev = m;
         m = (m == 0) ? 9 : m - 1;
         tick();
         chk("d1_dn_data", c_data, m);
         chk("d1_dn_udf", c_udf, (prev == 0));
      end
      c_decr = 0;

      // ---------------- E: DIGITS=8 random loads near limits ----------------
      for (int it = 0; it < 30; it++) begin
         if ($urandom_range(0, 1) == 1) m = 99999999 - $urandom_range(0, 3);
         else m = $urandom_range(0, 3);
         e_load = 1; e_ld = to_bcd(m);
         tick();
         e_load = 0;
         chk("d8_load", e_data, to_bcd(m));
         for (int s = 0; s < 5; s++) begin
            up = ($urandom_range(0, 1) == 1);
            e_incr = up; e_decr = !up;
            prev = m;
            if (up) m = (m == 99999999) ? 0 : m + 1;
            else    m = (m == 0) ? 99999999 : m - 1;
            tick();
            chk("d8_data", e_data, to_bcd(m));
            chk("d8_flags", {e_ovf, e_udf},
                {up && prev == 99999999, !up && prev == 0});
            chk("d8_bcd", all_bcd(e_data), 1'b1);
         end
         e_incr = 0; e_decr = 0;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
